// File: rtl/mont_exp_ctrl_pkg.sv
// Shared types for the modular-exponentiation sequencer: top states, op phases, operand selects.
// Purely declarative; no latency or flow-control of its own.
package mont_exp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TO_MONT,
        ST_SQUARE,
        ST_MULT,
        ST_FROM_MONT,
        ST_DONE
    } top_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_RST,
        PH_GO,
        PH_WAIT,
        PH_LATCH
    } op_phase_t;

    typedef enum logic [1:0] {
        SEL_X_R2,
        SEL_AA,
        SEL_AXT,
        SEL_A1
    } op_sel_t;

    function automatic op_sel_t state_to_sel(input top_state_t s);
        op_sel_t sel;
        case (s)
            ST_SQUARE:    sel = SEL_AA;
            ST_MULT:      sel = SEL_AXT;
            ST_FROM_MONT: sel = SEL_A1;
            default:      sel = SEL_X_R2;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Montgomery multiplier core link: start/done handshake, operands out, widened result back.
// Core result stays valid (mm_done high) until the core is reset; no other backpressure.
interface mont_exp_ctrl_if #(
    parameter int WIDTH = 512
);
    logic             mm_reset;
    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_m;
    logic [WIDTH+1:0] mm_result;
    logic             mm_done;

    modport master (
        output mm_reset, mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_reset, mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );
endinterface

// File: rtl/mont_exp_ctrl_op_seq.sv
// One multiplier op: RST -> GO -> WAIT(mm_done) -> LATCH; T_core + 3 cycles, back-to-back when more=1.
// Stalls in WAIT for as long as the core takes; go is only honoured from idle.
module mont_exp_ctrl_op_seq
    import mont_exp_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic more,
    input  logic mm_done,
    output logic mm_reset,
    output logic mm_start,
    output logic latch_en
);

    op_phase_t phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= PH_IDLE;
            mm_reset <= 1'b1;
            mm_start <= 1'b0;
            latch_en <= 1'b0;
        end else begin
            mm_start <= 1'b0;
            latch_en <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    mm_reset <= 1'b1;
                    if (go) phase <= PH_RST;
                end
                PH_RST: begin
                    phase    <= PH_GO;
                    mm_reset <= 1'b0;
                    mm_start <= 1'b1;
                end
                PH_GO: begin
                    phase <= PH_WAIT;
                end
                PH_WAIT: begin
                    if (mm_done) begin
                        phase    <= PH_LATCH;
                        latch_en <= 1'b1;
                    end
                end
                PH_LATCH: begin
                    // Core result is consumed this cycle; the next op (if any) resets the core.
                    mm_reset <= 1'b1;
                    phase    <= more ? PH_RST : PH_IDLE;
                end
                default: begin
                    phase    <= PH_IDLE;
                    mm_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right modexp over one Montgomery core: result = x^e mod m, (2 + EW + popcount(e)) core ops.
// MEXP_CONST_TIME_EN issues MULT for every exponent bit (2 + 2*EW ops); start ignored while busy.
module mont_exp_ctrl
    import mont_exp_ctrl_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int EW    = 512,
    parameter int CW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [EW-1:0]    in_e,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_r2,
    input  logic [WIDTH-1:0] in_rmodm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    mont_exp_ctrl_if.master  mm
);

    top_state_t       state;
    logic [WIDTH-1:0] x_q, m_q, r2_q, xt_q, a_q;
    logic [EW-1:0]    e_q;
    logic [CW-1:0]    bit_idx;

    logic             accept, more, latch_en, cur_bit, last_bit;
    logic             seq_mm_reset, seq_mm_start;
    logic [WIDTH-1:0] prod, op_a, op_b;
    logic             unused_mm_hi;
    op_sel_t          sel;

    assign accept       = start && (state == ST_IDLE || state == ST_DONE);
    assign more         = (state != ST_FROM_MONT);
    assign cur_bit      = |(e_q & (EW'(1) << bit_idx));
    assign last_bit     = (bit_idx == '0);
    assign prod         = mm.mm_result[WIDTH-1:0];
    assign unused_mm_hi = ^mm.mm_result[WIDTH+1:WIDTH];
    assign sel          = state_to_sel(state);

    // Operands derive from registers that only change on LATCH, so they hold across GO/WAIT.
    always_comb begin
        op_a = a_q;
        op_b = a_q;
        case (sel)
            SEL_X_R2: begin op_a = x_q; op_b = r2_q; end
            SEL_AA:   op_b = a_q;
            SEL_AXT:  op_b = xt_q;
            SEL_A1:   op_b = WIDTH'(1);
            default:  op_b = a_q;
        endcase
    end

    assign mm.mm_a     = op_a;
    assign mm.mm_b     = op_b;
    assign mm.mm_m     = m_q;
    assign mm.mm_reset = seq_mm_reset;
    assign mm.mm_start = seq_mm_start;

    mont_exp_ctrl_op_seq u_op_seq (
        .clk      (clk),
        .reset    (reset),
        .go       (accept),
        .more     (more),
        .mm_done  (mm.mm_done),
        .mm_reset (seq_mm_reset),
        .mm_start (seq_mm_start),
        .latch_en (latch_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            x_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            r2_q    <= '0;
            xt_q    <= '0;
            a_q     <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_q     <= in_x;
                        e_q     <= in_e;
                        m_q     <= in_m;
                        r2_q    <= in_r2;
                        a_q     <= in_rmodm;
                        bit_idx <= CW'(EW - 1);
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= ST_TO_MONT;
                    end
                end
                ST_TO_MONT: begin
                    if (latch_en) begin
                        xt_q  <= prod;
                        state <= ST_SQUARE;
                    end
                end
                ST_SQUARE: begin
                    if (latch_en) begin
                        a_q <= prod;
`ifdef MEXP_CONST_TIME_EN
                        state <= ST_MULT;
`else
                        if (cur_bit) begin
                            state <= ST_MULT;
                        end else if (last_bit) begin
                            state <= ST_FROM_MONT;
                        end else begin
                            bit_idx <= bit_idx - CW'(1);
                            state   <= ST_SQUARE;
                        end
`endif
                    end
                end
                ST_MULT: begin
                    if (latch_en) begin
`ifdef MEXP_CONST_TIME_EN
                        // Dummy multiply for a zero bit: timing matches, accumulator untouched.
                        if (cur_bit) a_q <= prod;
`else
                        a_q <= prod;
`endif
                        if (last_bit) begin
                            state <= ST_FROM_MONT;
                        end else begin
                            bit_idx <= bit_idx - CW'(1);
                            state   <= ST_SQUARE;
                        end
                    end
                end
                ST_FROM_MONT: begin
                    if (latch_en) begin
                        a_q    <= prod;
                        result <= prod;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboarded bench: behavioural Montgomery core with random latency, modexp reference model.
module tb_mont_exp_ctrl;

    localparam int WIDTH = 16;
    localparam int EW    = 8;
    localparam int CW    = 3;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               ops;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] in_x, in_m, in_r2, in_rmodm;
    logic [EW-1:0]    in_e;
    logic             busy, done;
    logic [WIDTH-1:0] result;

    mont_exp_ctrl_if #(.WIDTH(WIDTH)) mm_if ();

    mont_exp_ctrl #(.WIDTH(WIDTH), .EW(EW), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_x     (in_x),
        .in_e     (in_e),
        .in_m     (in_m),
        .in_r2    (in_r2),
        .in_rmodm (in_rmodm),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mm       (mm_if)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // a*b*2^-16 mod m, bit-serial REDC
    function automatic logic [WIDTH+1:0] mont(input logic [WIDTH-1:0] a, b, m);
        logic [63:0] t;
        t = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) t = t + 64'(b);
            if (t[0]) t = t + 64'(m);
            t = t >> 1;
        end
        if (t >= 64'(m)) t = t - 64'(m);
        return t[WIDTH+1:0];
    endfunction

    function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] x, input logic [EW-1:0] e,
                                                input logic [WIDTH-1:0] m);
        longint r, b;
        r = 1 % longint'(m);
        b = longint'(x) % longint'(m);
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * b) % longint'(m);
            b = (b * b) % longint'(m);
        end
        return r[WIDTH-1:0];
    endfunction

    function automatic int exp_ops(input logic [EW-1:0] e);
`ifdef MEXP_CONST_TIME_EN
        return 2 + 2 * EW;
`else
        return 2 + EW + $countones(e);
`endif
    endfunction

    // Behavioural core: resetn = ~(reset | mm_reset), done after 1..20 cycles, held until reset.
    logic [4:0]       core_cnt;
    logic             core_run;
    logic [WIDTH+1:0] core_pend;

    always @(posedge clk) begin
        if (reset || mm_if.mm_reset) begin
            core_run          <= 1'b0;
            core_cnt          <= '0;
            core_pend         <= '0;
            mm_if.mm_done     <= 1'b0;
            mm_if.mm_result   <= '0;
        end else if (mm_if.mm_start) begin
            core_run  <= 1'b1;
            core_cnt  <= 5'($urandom_range(1, 20));
            core_pend <= mont(mm_if.mm_a, mm_if.mm_b, mm_if.mm_m);
        end else if (core_run) begin
            if (core_cnt <= 5'd1) begin
                mm_if.mm_done   <= 1'b1;
                mm_if.mm_result <= core_pend;
                core_run        <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 5'd1;
            end
        end
    end

    // Monitor: handshake shape, operand stability, op count, scoreboard pop on done.
    initial begin
        logic             p_rst, p_start, p_busy, p_done, in_op, stab;
        logic [WIDTH-1:0] rec_a, rec_b;
        int               op_cnt;
        exp_t             ex;
        p_rst = 1'b1; p_start = 1'b0; p_busy = 1'b0; p_done = 1'b0;
        in_op = 1'b0; stab = 1'b1; op_cnt = 0; rec_a = '0; rec_b = '0;
        forever begin
            @(negedge clk);
            if (busy && !p_busy) op_cnt = 0;
            if (mm_if.mm_start) begin
                op_cnt++;
                chk("hs_rst_prev", 64'(p_rst), 64'd1);
                chk("hs_rst_low", 64'(mm_if.mm_reset), 64'd0);
                rec_a = mm_if.mm_a;
                rec_b = mm_if.mm_b;
                stab  = 1'b1;
                in_op = 1'b1;
            end else if (in_op) begin
                if (mm_if.mm_a !== rec_a || mm_if.mm_b !== rec_b) stab = 1'b0;
                if (mm_if.mm_done) begin
                    chk("opnd_stable", 64'(stab), 64'd1);
                    in_op = 1'b0;
                end
            end
            if (p_start) chk("hs_pulse", 64'(mm_if.mm_start), 64'd0);
            if (done && !p_done) begin
                if (exp_q.size() == 0) begin
                    chk("sb_size", 64'(exp_q.size()), 64'd1);
                end else begin
                    ex = exp_q.pop_front();
                    chk("result", 64'(result), 64'(ex.res));
                    chk("op_count", 64'(op_cnt), 64'(ex.ops));
                end
            end
            if (reset) in_op = 1'b0;
            p_rst   = mm_if.mm_reset;
            p_start = mm_if.mm_start;
            p_busy  = busy;
            p_done  = done;
        end
    end

    task automatic set_inputs(input logic [WIDTH-1:0] x, input logic [EW-1:0] e, input logic [WIDTH-1:0] m);
        longint r;
        r        = 65536 % longint'(m);
        in_x     = x;
        in_e     = e;
        in_m     = m;
        in_rmodm = r[WIDTH-1:0];
        r        = (r * r) % longint'(m);
        in_r2    = r[WIDTH-1:0];
    endtask

    // Caller is just past a negedge.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [EW-1:0] e, input logic [WIDTH-1:0] m,
                         input bit push);
        exp_t ex;
        set_inputs(x, e, m);
        start = 1'b1;
        if (push) begin
            ex.res = modexp(x, e, m);
            ex.ops = exp_ops(e);
            exp_q.push_back(ex);
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_done", 64'(done), 64'd0);
        #1;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            chk("timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [WIDTH-1:0] x, input logic [EW-1:0] e, input logic [WIDTH-1:0] m);
        issue(x, e, m, 1'b1);
        wait_drain();
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] rm, rx;
        logic [EW-1:0]    re;
        reset = 1'b1;
        start = 1'b0;
        in_x = '0; in_e = '0; in_m = '0; in_r2 = '0; in_rmodm = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_mm_start", 64'(mm_if.mm_start), 64'd0);
        chk("rst_mm_reset", 64'(mm_if.mm_reset), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        #1;

        run(16'd3, 8'd5, 16'd7);
        run(16'd9, 8'd0, 16'd13);
        run(16'd9, 8'd1, 16'd13);
        run(16'd2, 8'hFF, 16'hFFF1);

        // Start mid-run with other operands must be ignored.
        issue(16'd3, 8'd5, 16'd7, 1'b1);
        repeat (30) @(negedge clk);
        #1;
        set_inputs(16'd4, 8'd3, 16'd11);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("ignored_busy", 64'(busy), 64'd1);
        #1;
        wait_drain();

        // Reset while the fifth op is waiting on the core.
        issue(16'd11, 8'hC5, 16'h01F3, 1'b0);
        n = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (mm_if.mm_start) n++;
            if (n == 5) break;
        end
        if (n != 5) chk("rst_reach", 64'(n), 64'd5);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_mm_reset", 64'(mm_if.mm_reset), 64'd1);
        chk("mid_rst_result", 64'(result), 64'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        run(16'd5, 8'h6D, 16'h03B3);

        // Back-to-back: second start lands while done is high.
        run(16'h0123, 8'hA5, 16'h7FFF);
        run(16'h0042, 8'h80, 16'h1001);

        for (int k = 0; k < 4; k++) begin
            rm = 16'($urandom_range(3, 16'hFFFF)) | 16'd1;
            rx = 16'($urandom_range(0, int'(rm) - 1));
            re = 8'($urandom_range(0, 255));
            run(rx, re, rm);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
